// File: rtl/sdrd_bit_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdrd_bit_collector: strobes the CLE16 serial-data-read window and packs the
//   returned SDRD bits into a word of up to 16 bits for a valid/ready host.
//   Optional feature macro: SDRD_PARITY_EN (registered XOR of collected bits).
// Revision: 1.0
// ---------------------------------------------------------------------------
module sdrd_bit_collector #(
  parameter int BUS_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [4:0]        cmd_len,
  output logic [BUS_AW-1:0] bus_addr,
  output logic              bus_rw,
  output logic              bus_sel_n,
  input  logic              sdrd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic [4:0]        rsp_count,
  output logic              rsp_parity
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_GAP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_op;
  logic [4:0]  r_len;
  logic [4:0]  r_cnt;
  logic [14:0] r_shift;

  logic [4:0]  w_len_eff;
  logic [4:0]  w_cnt_next;
  logic [15:0] w_shift_next;
  logic        w_last;

  // 0 and anything above 16 both mean a full 16-bit word
  assign w_len_eff    = (cmd_len == 5'd0 || cmd_len > 5'd16) ? 5'd16 : cmd_len;
  assign w_cnt_next   = r_cnt + 5'd1;
  assign w_shift_next = {r_shift, sdrd};
  assign w_last       = (w_cnt_next == r_len);
  assign cmd_ready    = (r_state == S_IDLE);

  function automatic logic [BUS_AW-1:0] f_strobe_addr(input logic [3:0] op);
    f_strobe_addr       = '0;
    f_strobe_addr[12]   = 1'b1;
    f_strobe_addr[7:4]  = op;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= 4'd0;
      r_len     <= 5'd0;
      r_cnt     <= 5'd0;
      r_shift   <= 15'd0;
      bus_addr  <= '0;
      bus_rw    <= 1'b0;
      bus_sel_n <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
      rsp_count <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op      <= cmd_op;
            r_len     <= w_len_eff;
            r_cnt     <= 5'd0;
            r_shift   <= 15'd0;
            bus_sel_n <= 1'b0;
            bus_rw    <= 1'b1;
            bus_addr  <= f_strobe_addr(cmd_op);
            r_state   <= S_STROBE;
          end
        end
        S_STROBE: begin
          r_shift   <= w_shift_next[14:0];
          r_cnt     <= w_cnt_next;
          bus_sel_n <= 1'b1;
          bus_rw    <= 1'b0;
          bus_addr  <= '0;
          // shift starts cleared, so the word is already right-aligned
          if (w_last) begin
            rsp_valid <= 1'b1;
            rsp_data  <= w_shift_next;
            rsp_count <= r_len;
            r_state   <= S_DONE;
          end else begin
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          bus_sel_n <= 1'b0;
          bus_rw    <= 1'b1;
          bus_addr  <= f_strobe_addr(r_op);
          r_state   <= S_STROBE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SDRD_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par      <= 1'b0;
      rsp_parity <= 1'b0;
    end else if (r_state == S_IDLE && cmd_valid) begin
      r_par <= 1'b0;
    end else if (r_state == S_STROBE) begin
      r_par <= r_par ^ sdrd;
      if (w_last) rsp_parity <= r_par ^ sdrd;
    end
  end
`else
  assign rsp_parity = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sdrd_bit_collector.md
# sdrd_bit_collector

Host-side bus master that drives the serial-data-read window of the CLE16 key logic. It turns one command into a burst of single-cycle read strobes at the window (BA13=0, BA12=1). Each strobe advances the key state machine; the block samples the returned SDRD bit on the same edge and packs up to 16 bits into one word. The result goes to the host through a valid/ready response channel.

## Interface
Parameters:
- BUS_AW, 14, width of the bus address output; must be ≥ 14.

Ports:
- clk  in  1  single clock; every register updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_op  in  4  value driven on bus_addr[7:4] for every strobe of the command.
- cmd_len  in  5  number of bits to collect; 1..16 as given, 0 means 16, values above 16 are clamped to 16.
- bus_addr  out  BUS_AW  window address.
- bus_rw  out  1  1 = read; high only during strobe cycles.
- bus_sel_n  out  1  active-low select (SSER); low for exactly one cycle per bit.
- sdrd  in  1  serial data returned by the key logic.
- rsp_valid  out  1  collected word available.
- rsp_ready  in  1  host accepts the word.
- rsp_data  out  16  collected bits, right-aligned.
- rsp_count  out  5  number of bits in rsp_data, 1..16.
- rsp_parity  out  1  XOR of the collected bits; 0 when SDRD_PARITY_EN is not defined.

## Operation
States:
- IDLE: cmd_ready=1. The handshake cmd_valid&cmd_ready latches op, effective length and the clears. On handshake → STROBE.
- STROBE: bus_sel_n=0, bus_rw=1, bus_addr[13]=0, bus_addr[12]=1, bus_addr[7:4]=op, all other address bits 0.
  - At the closing edge: shift = {shift[14:0], sdrd}, cnt += 1, par ^= sdrd.
  - If cnt reaches len → DONE; otherwise → GAP.
- GAP: bus_sel_n=1, bus_rw=0, bus_addr=0. One cycle, then → STROBE.
- DONE: rsp_valid=1. rsp_data, rsp_count and rsp_parity are stable until the handshake. On rsp_valid&rsp_ready → IDLE.

Data rules:
- The first sampled bit ends up at rsp_data[len-1], the last at rsp_data[0].
- Bits [15:len] are 0.
- The shift register and parity are cleared on command accept.

Boundary behaviour:
- cmd_valid is ignored outside IDLE, and cmd_op/cmd_len changes are not observed mid-command.
- If rsp_ready is held high, rsp_valid lasts exactly one cycle.
- rsp_ready while not in DONE has no effect.
- Reset (any state, including mid-burst): immediately state=IDLE, bus_sel_n=1, bus_rw=0, bus_addr=0, rsp_valid=0, rsp_data=0, rsp_count=0, rsp_parity=0, cmd_ready=1. No partial response is ever emitted.
- sdrd is sampled only at the closing edge of a STROBE cycle; its value at any other time is don't-care.

## Timing
- Commands are accepted at edge E0. Strobes occupy cycles 1, 3, 5, …, 2·len−1, with GAP cycles between them; there is no GAP after the final strobe.
- rsp_valid rises in cycle 2·len after E0.
- cmd_ready returns the cycle after the response handshake.
- Minimum command-to-command period: 2·len+1 cycles.
- Every output is registered except cmd_ready, which decodes state directly. All bus outputs come from flops, so there are no glitches on bus_sel_n.

## Configuration
- SDRD_PARITY_EN defined:
  - rsp_parity is the registered XOR of all bits collected in the command.
  - It is valid with rsp_valid and held until the handshake.
- Not defined:
  - The par register is absent and rsp_parity is constant 0.
  - All other behaviour and timing are identical.

## Test plan
- cmd_op=4'h2, cmd_len=8, sdrd pattern 1,0,1,1,0,0,1,0 → 8 strobes with bus_addr=0x1020, rsp_data=0x00B2, rsp_count=8, rsp_valid in cycle 16, rsp_parity=0 (with SDRD_PARITY_EN).
- cmd_len=0 with sdrd constant 1 → 16 strobes, rsp_data=0xFFFF, rsp_count=16; cmd_len=20 gives the same result.
- cmd_len=1, sdrd=1, rsp_ready held low 5 cycles → rsp_valid high from cycle 2 and held with rsp_data=0x0001; cmd_ready rises only after the handshake.
- cmd_valid pulsed with cmd_len=3 during the third strobe of a 4-bit command → ignored: exactly 4 strobes, rsp_count=4.
- rst_n asserted during the GAP after strobe 5 of 12 → bus_sel_n=1 and cmd_ready=1 with no clock edge; no rsp_valid; the next command gives a fresh result from bit 0.
- Back-to-back 2-bit commands with rsp_ready tied high → bus_sel_n low in cycles 1 and 3, rsp_valid in cycle 4, next command accepted at edge 5, next strobe in cycle 6.
